param_down_timer: RTL and testbench
===================================

Name: param_down_timer

Overview:
- Parametrised successor to the single-width loadable down-counter.
- Counts a loaded start value down to zero on enabled ticks.
- Three run modes: one-shot, periodic auto-reload, free-running wrap.
- Outputs a terminal-count pulse, a sticky done flag and a busy flag; used as the general timing source for display refresh, debounce and LED blink logic.

Parameters:
- WIDTH, 8, bit width of start value, reload register and count.
- PRESCALE_W, 4, width of prescaler divide field (present only with optional feature).

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high; clears all state
- enable  input  1  count permitted on this cycle (ANDed with tick)
- load  input  1  capture start_value into reload register and count
- start_value  input  WIDTH  value captured on load
- mode  input  2  00 ONE_SHOT, 01 PERIODIC, 10 FREE, 11 treated as ONE_SHOT
- clear_done  input  1  clears sticky done flag
- count  output  WIDTH  current count (registered)
- tc_pulse  output  1  one-cycle pulse when count reaches 0 by decrement
- done  output  1  sticky; set on ONE_SHOT completion
- busy  output  1  high while state is RUN
- prescale_div  input  PRESCALE_W  present only when optional feature compiled in

Behaviour:
- Interface decision: one clock, clk; reset is synchronous and active-high, port name reset.
- Reset values: count=0, reload=0, tc_pulse=0, done=0, busy=0, state=IDLE.
- States:
  - IDLE: after reset; count holds.
  - RUN: decrements on step = enable & tick.
  - DONE: ONE_SHOT finished; count holds at 0.
- Priority per cycle: reset > load > step > hold.
- Load:
  - reload<=start_value, count<=start_value, done<=0.
  - State goes to RUN if start_value!=0. Otherwise state goes to DONE, done<=1, no tc_pulse.
  - Load during RUN restarts immediately; the same-cycle step is discarded.
- Step in RUN with count>1: count<=count-1.
- Step in RUN with count==1: count<=0 and tc_pulse<=1 (visible the cycle count first reads 0). Then by mode:
  - ONE_SHOT: state->DONE, done<=1.
  - PERIODIC or FREE: stay RUN.
- Step in RUN with count==0:
  - PERIODIC: count<=reload, no pulse. Period = reload+1 steps.
  - FREE: count<=all-ones (wrap), no pulse.
- tc_pulse: exactly one cycle wide, deasserted on every cycle without the 1->0 transition.
- enable=0: count, state and flags hold. Enable may toggle mid-run without loss.
- mode change mid-run takes effect at the next step.
- clear_done: done<=0 unless done is being set on the same cycle (set wins). State stays DONE until the next load.
- busy = (state==RUN), registered.
- Latency: load to count visible = 1 cycle. Step to new count = 1 cycle.
- Width arithmetic: unsigned, modulo 2^WIDTH; no signed handling.

Optional Feature:
- Macro: PARAM_DOWN_TIMER_PRESCALE_EN.
- Defined:
  - prescale_div port exists; internal prescaler counter generates tick once every prescale_div+1 enabled cycles.
  - Prescaler resets to 0 on reset or load; it only advances while enable=1.
  - prescale_div=0 gives tick every cycle.
- Undefined: no prescale_div port; tick tied to 1, so one step per enabled cycle.

Decomposition:
- Shared package/header holds:
  - mode encodings MODE_ONE_SHOT=2'b00, MODE_PERIODIC=2'b01, MODE_FREE=2'b10
  - state encodings ST_IDLE, ST_RUN, ST_DONE
- Sub-module tick_prescaler (parameter PRESCALE_W; ports clk, reset, clear, enable, div, tick). Instantiated only under the macro.

Test Plan:
- ONE_SHOT: reset, load 27, enable held:
  - count 27..0 over 27 enabled cycles.
  - tc_pulse one cycle at count=0; done=1; busy=0; count holds 0 with enable still high.
- PERIODIC: load 3, enable held:
  - count sequence 3,2,1,0,3,2,1,0.
  - tc_pulse every 4th cycle; done stays 0.
- FREE, WIDTH=8: load 1, enable:
  - count 1,0,255,254.
  - single tc_pulse at 0; busy stays 1.
- Enable gaps and reload:
  - load 10, enable 5 cycles, drop 3 cycles, count holds 5.
  - load 7 mid-run, next cycle count=7.
  - Synchronous reset mid-run: count=0, busy=0 next cycle.
- Edge cases:
  - Load 0 in ONE_SHOT: done=1 next cycle, no tc_pulse.
  - clear_done concurrent with completion: done remains 1.
  - Later clear_done alone: done=0.
- With PARAM_DOWN_TIMER_PRESCALE_EN and prescale_div=2: load 4, enable; count decrements every 3rd cycle, reaching 0 after 12 cycles.

Source files
------------

// File: rtl/param_down_timer_pkg.sv
// Shared encodings for param_down_timer: run modes and controller states.
package param_down_timer_pkg;

    localparam int unsigned MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_ONE_SHOT = 2'b00,
        MODE_PERIODIC = 2'b01,
        MODE_FREE     = 2'b10
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage : param_down_timer_pkg

// File: rtl/param_down_timer_tick_prescaler.sv
// Divides enabled cycles into one tick every div+1 enabled cycles; cleared by reset or clear.
module tick_prescaler #(
    parameter int unsigned PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  enable,
    input  logic [PRESCALE_W-1:0] div,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] cnt_q;
    logic [PRESCALE_W-1:0] cnt_d;
    logic                  wrap_c;

    // >= keeps the divider from running away if div shrinks below the current count
    assign wrap_c = (cnt_q >= div);
    assign tick   = enable & wrap_c;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = wrap_c ? '0 : cnt_q + PRESCALE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : tick_prescaler

// File: rtl/param_down_timer.sv
// Loadable down-timer with one-shot, periodic-reload and free-running wrap modes.
// Optional tick prescaler enabled by defining PARAM_DOWN_TIMER_PRESCALE_EN.
module param_down_timer
    import param_down_timer_pkg::*;
#(
    parameter int unsigned WIDTH = 8
`ifdef PARAM_DOWN_TIMER_PRESCALE_EN
    ,
    parameter int unsigned PRESCALE_W = 4
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  load,
    input  logic [WIDTH-1:0]      start_value,
    input  logic [MODE_W-1:0]     mode,
    input  logic                  clear_done,
    output logic [WIDTH-1:0]      count,
    output logic                  tc_pulse,
    output logic                  done,
    output logic                  busy
`ifdef PARAM_DOWN_TIMER_PRESCALE_EN
    ,
    input  logic [PRESCALE_W-1:0] prescale_div
`endif
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q, tc_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             tick_c;
    logic             step_c;

`ifdef PARAM_DOWN_TIMER_PRESCALE_EN
    tick_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .clear  (load),
        .enable (enable),
        .div    (prescale_div),
        .tick   (tick_c)
    );
`else
    assign tick_c = 1'b1;
`endif

    assign step_c = enable & tick_c;

    // Next-state: load beats step; a completing step beats clear_done.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        tc_d     = 1'b0;
        done_d   = done_q;

        if (clear_done) begin
            done_d = 1'b0;
        end

        if (load) begin
            reload_d = start_value;
            count_d  = start_value;
            if (start_value != '0) begin
                state_d = ST_RUN;
                done_d  = 1'b0;
            end else begin
                state_d = ST_DONE;
                done_d  = 1'b1;
            end
        end else if (step_c && (state_q == ST_RUN)) begin
            if (count_q > WIDTH'(1)) begin
                count_d = count_q - WIDTH'(1);
            end else if (count_q == WIDTH'(1)) begin
                count_d = '0;
                tc_d    = 1'b1;
                if ((mode != MODE_PERIODIC) && (mode != MODE_FREE)) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end else begin
                // count==0 while running: only reachable in the wrapping modes or after a mode switch
                case (mode)
                    MODE_PERIODIC: count_d = reload_q;
                    MODE_FREE:     count_d = '1;
                    default: begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                endcase
            end
        end

        busy_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            reload_q <= '0;
            tc_q     <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign count    = count_q;
    assign tc_pulse = tc_q;
    assign done     = done_q;
    assign busy     = busy_q;

endmodule : param_down_timer

// File: tb/tb_param_down_timer.sv
// Directed self-checking bench for param_down_timer (WIDTH=8).
module tb_param_down_timer;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             reset;
    logic             enable;
    logic             load;
    logic [WIDTH-1:0] start_value;
    logic [1:0]       mode;
    logic             clear_done;
    logic [WIDTH-1:0] count;
    logic             tc_pulse;
    logic             done;
    logic             busy;
`ifdef PARAM_DOWN_TIMER_PRESCALE_EN
    logic [3:0]       prescale_div;
`endif

    int checks;
    int errors;

    param_down_timer #(
        .WIDTH (WIDTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .load        (load),
        .start_value (start_value),
        .mode        (mode),
        .clear_done  (clear_done),
        .count       (count),
        .tc_pulse    (tc_pulse),
        .done        (done),
        .busy        (busy)
`ifdef PARAM_DOWN_TIMER_PRESCALE_EN
        ,
        .prescale_div (prescale_div)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock and settle past the edge before sampling/driving.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [WIDTH-1:0] v);
        load        = 1'b1;
        start_value = v;
        cyc();
        load        = 1'b0;
    endtask

    initial begin
        clk         = 1'b0;
        reset       = 1'b1;
        enable      = 1'b0;
        load        = 1'b0;
        start_value = '0;
        mode        = 2'b00;
        clear_done  = 1'b0;
        checks      = 0;
        errors      = 0;
`ifdef PARAM_DOWN_TIMER_PRESCALE_EN
        prescale_div = 4'd0;
`endif
        cyc();
        cyc();
        check("rst_count", 32'(count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_tc", 32'(tc_pulse), 32'd0);
        reset = 1'b0;

        // One-shot from 27 with enable held through completion
        mode   = 2'b00;
        enable = 1'b1;
        do_load(8'd27);
        check("os_load_count", 32'(count), 32'd27);
        check("os_load_busy", 32'(busy), 32'd1);
        for (int i = 1; i <= 27; i++) begin
            cyc();
            check("os_count", 32'(count), 32'(27 - i));
            check("os_tc", 32'(tc_pulse), (i == 27) ? 32'd1 : 32'd0);
            check("os_done", 32'(done), (i == 27) ? 32'd1 : 32'd0);
        end
        check("os_busy_end", 32'(busy), 32'd0);
        for (int i = 0; i < 2; i++) begin
            cyc();
            check("os_hold_count", 32'(count), 32'd0);
            check("os_hold_tc", 32'(tc_pulse), 32'd0);
            check("os_hold_done", 32'(done), 32'd1);
        end

        // Periodic reload of 3: period of four steps
        mode = 2'b01;
        do_load(8'd3);
        check("per_load_count", 32'(count), 32'd3);
        check("per_load_done", 32'(done), 32'd0);
        begin
            int exp_seq [7] = '{2, 1, 0, 3, 2, 1, 0};
            for (int i = 0; i < 7; i++) begin
                cyc();
                check("per_count", 32'(count), 32'(exp_seq[i]));
                check("per_tc", 32'(tc_pulse), (exp_seq[i] == 0) ? 32'd1 : 32'd0);
                check("per_done", 32'(done), 32'd0);
                check("per_busy", 32'(busy), 32'd1);
            end
        end

        // Free-running wrap through all-ones
        mode = 2'b10;
        do_load(8'd1);
        check("free_load_count", 32'(count), 32'd1);
        begin
            int exp_seq [3] = '{0, 255, 254};
            for (int i = 0; i < 3; i++) begin
                cyc();
                check("free_count", 32'(count), 32'(exp_seq[i]));
                check("free_tc", 32'(tc_pulse), (i == 0) ? 32'd1 : 32'd0);
                check("free_busy", 32'(busy), 32'd1);
            end
        end

        // Enable gaps, reload mid-run and reset mid-run
        mode   = 2'b00;
        enable = 1'b0;
        do_load(8'd10);
        check("gap_load_count", 32'(count), 32'd10);
        enable = 1'b1;
        repeat (5) cyc();
        check("gap_after5", 32'(count), 32'd5);
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("gap_hold_count", 32'(count), 32'd5);
            check("gap_hold_busy", 32'(busy), 32'd1);
        end
        enable = 1'b1;
        do_load(8'd7);
        check("reload_count", 32'(count), 32'd7);
        cyc();
        check("reload_step", 32'(count), 32'd6);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("midrst_count", 32'(count), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);

        // Load of zero completes immediately with no pulse
        do_load(8'd0);
        check("zero_done", 32'(done), 32'd1);
        check("zero_tc", 32'(tc_pulse), 32'd0);
        check("zero_busy", 32'(busy), 32'd0);
        check("zero_count", 32'(count), 32'd0);
        clear_done = 1'b1;
        cyc();
        clear_done = 1'b0;
        check("clr_alone0", 32'(done), 32'd0);

        // clear_done coinciding with completion loses to the set
        do_load(8'd2);
        cyc();
        check("race_pre", 32'(count), 32'd1);
        clear_done = 1'b1;
        cyc();
        clear_done = 1'b0;
        check("race_count", 32'(count), 32'd0);
        check("race_tc", 32'(tc_pulse), 32'd1);
        check("race_done", 32'(done), 32'd1);
        cyc();
        check("race_done_hold", 32'(done), 32'd1);
        clear_done = 1'b1;
        cyc();
        clear_done = 1'b0;
        check("clr_later", 32'(done), 32'd0);
        check("clr_busy", 32'(busy), 32'd0);
        check("clr_count", 32'(count), 32'd0);

`ifdef PARAM_DOWN_TIMER_PRESCALE_EN
        // Prescale by 3: one decrement every third enabled cycle
        prescale_div = 4'd2;
        mode         = 2'b00;
        do_load(8'd4);
        for (int i = 1; i <= 12; i++) begin
            cyc();
            check("pre_count", 32'(count), 32'(4 - i / 3));
        end
        check("pre_done", 32'(done), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_param_down_timer
